// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer that runs one add/sub/mul/div at a time through
// combinational datapath units and hands the result out on valid/ready.

module full_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module full_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  logic [WIDTH:0] ext;

  // The extra top bit goes to 1 exactly when a < b + bin, i.e. the borrow.
  assign ext  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  assign diff = ext[WIDTH-1:0];
  assign bout = ext[WIDTH];
endmodule

module multiplier #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);
  assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

module divider #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  always_comb begin
    if (b == '0) begin
      quotient  = '1;
      remainder = a;
      div_zero  = 1'b1;
    end else begin
      quotient  = a / b;
      remainder = a % b;
      div_zero  = 1'b0;
    end
  end
endmodule

module alu_op_sequencer #(
  parameter int WIDTH      = 4,
  parameter int ADDSUB_LAT = 1,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_low,
  output logic [WIDTH-1:0] result_high,
  output logic             carry,
  output logic             div_zero,
  output logic             busy,
  output logic [7:0]       ops_done
);
  localparam int MAX_AM  = (ADDSUB_LAT > MUL_LAT) ? ADDSUB_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;

  function automatic logic [CNT_W-1:0] lat_m1(input op_e o);
    case (o)
      OP_ADD, OP_SUB: return CNT_W'(ADDSUB_LAT - 1);
      OP_MUL:         return CNT_W'(MUL_LAT - 1);
      default:        return CNT_W'(DIV_LAT - 1);
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               carry_q, carry_d, dz_q, dz_d;
  logic [7:0]         ops_done_q, ops_done_d;

  logic [WIDTH-1:0]   add_sum, sub_diff, div_quo, div_rem;
  logic               add_cout, sub_bout, div_dz;
  logic [2*WIDTH-1:0] mul_prod;

  // Datapath sees only the latched operands, so it settles undisturbed.
  full_adder      #(.WIDTH(WIDTH)) u_add (.a(a_q), .b(b_q), .cin(1'b0), .sum(add_sum), .cout(add_cout));
  full_subtractor #(.WIDTH(WIDTH)) u_sub (.a(a_q), .b(b_q), .bin(1'b0), .diff(sub_diff), .bout(sub_bout));
  multiplier      #(.WIDTH(WIDTH)) u_mul (.a(a_q), .b(b_q), .product(mul_prod));
  divider         #(.WIDTH(WIDTH)) u_div (.a(a_q), .b(b_q), .quotient(div_quo),
                                          .remainder(div_rem), .div_zero(div_dz));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    carry_d    = carry_q;
    dz_d       = dz_q;
    ops_done_d = ops_done_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(op);
          a_d     = in1;
          b_d     = in2;
          cnt_d   = lat_m1(op_e'(op));
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          hi_d    = '0;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          case (op_q)
            OP_ADD: begin
              lo_d    = add_sum;
              carry_d = add_cout;
            end
            OP_SUB: begin
              lo_d    = sub_diff;
              carry_d = sub_bout;
            end
            OP_MUL: {hi_d, lo_d} = mul_prod;
            default: begin
              lo_d = div_quo;
              hi_d = div_rem;
              dz_d = div_dz;
            end
          endcase
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          ops_done_d = ops_done_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: operand and result registers are reset too, because the result
    // outputs are observable straight after reset.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      carry_q    <= 1'b0;
      dz_q       <= 1'b0;
      ops_done_q <= 8'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      carry_q    <= carry_d;
      dz_q       <= dz_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result_low  = lo_q;
  assign result_high = hi_q;
  assign carry       = carry_q;
  assign div_zero    = dz_q;
  assign ops_done    = ops_done_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: driver pushes model results into a
// queue, a negedge monitor checks every presented result against it.

module tb_alu_op_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] in1, in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_low, result_high;
  logic         carry, div_zero, busy;
  logic [7:0]   ops_done;

  logic ready_force;
  logic rand_ready;
  logic rnd_ready;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         carry;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_ops;
  int         cyc;
  int         n_cmp;
  int         n_err;
  logic       prev_ov;

  assign out_ready = rand_ready ? rnd_ready : ready_force;

  alu_op_sequencer #(.WIDTH(W), .ADDSUB_LAT(1), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .result_low(result_low), .result_high(result_high), .carry(carry),
    .div_zero(div_zero), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial rnd_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic exp_t model(input int o, input int a, input int b, input int acc);
    exp_t e;
    int   full;
    int   r;
    full    = 1 << W;
    e.acc   = acc;
    e.hi    = '0;
    e.carry = 1'b0;
    e.dz    = 1'b0;
    case (o)
      0: begin
        r = a + b;
        e.lo = W'(r % full); e.carry = (r >= full); e.lat = 1;
      end
      1: begin
        r = a - b;
        e.lo = W'((r + full) % full); e.carry = (r < 0); e.lat = 1;
      end
      2: begin
        r = a * b;
        e.lo = W'(r % full); e.hi = W'(r / full); e.lat = 2;
      end
      default: begin
        e.lat = 4;
        if (b == 0) begin
          e.lo = W'(full - 1); e.hi = W'(a); e.dz = 1'b1;
        end else begin
          e.lo = W'(a / b); e.hi = W'(a % b);
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: compares every cycle a result is presented; pops on handshake.
  always @(negedge clk) begin
    exp_t cur;
    if (!rst_n) begin
      exp_q.delete();
      exp_ops = 8'd0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        cur = exp_q[0];
        if (!prev_ov) check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
        check("result_low", 32'(result_low), 32'(cur.lo));
        check("result_high", 32'(result_high), 32'(cur.hi));
        check("carry", 32'(carry), 32'(cur.carry));
        check("div_zero", 32'(div_zero), 32'(cur.dz));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        check("ops_done", 32'(ops_done), 32'(exp_ops));
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_ops = exp_ops + 8'd1;
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic issue(input int o, input int a, input int b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    op       = 2'(o);
    in1      = W'(a);
    in2      = W'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(o, a, b, cyc));
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && in_ready) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, {24'd0, result_high, result_low}, 32'd0);
    check({tag, "_flags"}, {30'd0, carry, div_zero}, 32'd0);
    check({tag, "_ops_done"}, 32'(ops_done), 32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    exp_ops     = 8'd0;
    prev_ov     = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    op          = 2'd0;
    in1         = '0;
    in2         = '0;
    ready_force = 1'b1;
    rand_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("reset");

    // Directed operations, including the borrow and divide-by-zero corners.
    issue(0, 9, 8);
    issue(1, 3, 5);
    issue(1, 7, 2);
    issue(2, 13, 11);
    issue(3, 13, 4);
    issue(3, 6, 0);
    issue(0, 1, 2);
    drain();
    check("ops_after_directed", 32'(ops_done), 32'd7);

    // Backpressure with command inputs churning while the sequencer is busy.
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    issue(2, 5, 3);
    repeat (12) begin
      @(negedge clk);
      in1      = W'($urandom_range(0, 15));
      in2      = W'($urandom_range(0, 15));
      op       = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    check("bp_held_valid", 32'(out_valid), 32'd1);
    check("bp_no_count", 32'(ops_done), 32'd7);
    in_valid    = 1'b0;
    ready_force = 1'b1;
    drain();
    check("ops_after_bp", 32'(ops_done), 32'd8);

    // Reset sampled on the second edge after accepting a divide.
    issue(3, 15, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("mid_exec_reset");

    issue(0, 1, 1);
    drain();
    check("ops_after_reset", 32'(ops_done), 32'd1);

    // Random traffic with random backpressure; 256 total ops wraps the count.
    rand_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    drain();
    rand_ready = 1'b0;
    check("ops_wrap", 32'(ops_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
